// File: rtl/dcache_resp_pkg.sv
// Shared types and helpers for the dcache store-buffer responder.
// State encoding, latency width and the per-lane byte merge used by the write front-end.
package dcache_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } resp_state_e;

    localparam int MEM_DEPTH_DEF = 64;
    localparam int WORD_IDX_W    = $clog2(MEM_DEPTH_DEF);
    localparam int LAT_W         = 2;
    localparam int DATA_W_DEF    = 32;
    localparam int SEL_W_DEF     = DATA_W_DEF / 8;

    function automatic logic [DATA_W_DEF-1:0] byte_merge(
        input logic [DATA_W_DEF-1:0] old_word,
        input logic [DATA_W_DEF-1:0] new_word,
        input logic [SEL_W_DEF-1:0]  sel
    );
        logic [DATA_W_DEF-1:0] merged;
        merged = old_word;
        for (int i = 0; i < SEL_W_DEF; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_resp_mem.sv
// Word memory for the dcache responder: one byte-wide array per lane so each
// lane's write enable is independent; async clear and a combinational debug read.
module dcache_resp_mem #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int MEM_DEPTH      = 64,
    localparam int IDX_W         = $clog2(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] sel,
    input  logic [IDX_W-1:0]          dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_SEL_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int w = 0; w < MEM_DEPTH; w++) begin
                        lane_mem[w] <= 8'h00;
                    end
                end else if (we && sel[gi]) begin
                    lane_mem[waddr] <= wdata[8*gi +: 8];
                end
            end

            assign dbg_rdata[8*gi +: 8] = lane_mem[dbg_addr];
        end
    endgenerate

endmodule

// File: rtl/dcache_stb_responder.sv
// Dcache-side responder for the store buffer write handshake: accepts one store,
// commits it byte-masked after lat_cfg extra cycles and pulses dcache2stb_ack.
// Optional DCACHE_RESP_ERR_EN adds dcache2stb_err for out-of-range or word-crossing stores.
module dcache_stb_responder
    import dcache_resp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int MEM_DEPTH      = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]        stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0]    stb2dcache_sel_byte,
    input  logic                         stb2dcache_w_en,
    input  logic                         stb2dcache_req,
    input  logic                         dmem_sel_o,
    input  logic [LAT_W-1:0]             lat_cfg,
    output logic                         dcache2stb_ack,
`ifdef DCACHE_RESP_ERR_EN
    output logic                         dcache2stb_err,
`endif
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         wr_count,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int OFF_W = $clog2(BYTE_SEL_WIDTH);

    resp_state_e                state_reg;
    logic [LAT_W-1:0]           lat_cnt_reg;
    logic [ADDR_WIDTH-1:0]      addr_reg;
    logic [DATA_WIDTH-1:0]      wdata_reg;
    logic [BYTE_SEL_WIDTH-1:0]  sel_reg;
    logic                       w_en_reg;
    logic                       ack_reg;
    logic                       busy_reg;
    logic                       err_reg;
    logic [CNT_WIDTH-1:0]       wr_count_reg;

    logic                       accept;
    logic                       commit;
    logic                       req_err;
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      src_addr;
    logic [DATA_WIDTH-1:0]      src_wdata;
    logic [BYTE_SEL_WIDTH-1:0]  src_sel;
    logic                       src_w_en;

    // A zero-latency store commits on its accept edge, before the capture
    // registers hold it, so the write source follows the live inputs in IDLE.
    always_comb begin
        accept = (state_reg == IDLE) && stb2dcache_req && dmem_sel_o;
        if (state_reg == IDLE) begin
            src_addr  = stb2dcache_addr;
            src_wdata = stb2dcache_wdata;
            src_sel   = stb2dcache_sel_byte;
            src_w_en  = stb2dcache_w_en;
        end else begin
            src_addr  = addr_reg;
            src_wdata = wdata_reg;
            src_sel   = sel_reg;
            src_w_en  = w_en_reg;
        end
        commit = (accept && (lat_cfg == '0)) ||
                 ((state_reg == WAIT) && (lat_cnt_reg == LAT_W'(1)));
    end

`ifdef DCACHE_RESP_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * BYTE_SEL_WIDTH);

    always_comb begin
        req_err = (src_addr >= ADDR_LIMIT);
        for (int i = 0; i < BYTE_SEL_WIDTH; i++) begin
            if (src_sel[i] && ((int'(src_addr[OFF_W-1:0]) + i) >= BYTE_SEL_WIDTH)) begin
                req_err = 1'b1;
            end
        end
    end

    assign dcache2stb_err = err_reg;
`else
    assign req_err = 1'b0;

    // Without range checking, high and offset address bits are simply dropped.
    logic unused_sink;
    assign unused_sink = ^{src_addr[ADDR_WIDTH-1:IDX_W+OFF_W], src_addr[OFF_W-1:0], err_reg};
`endif

    assign mem_we = commit && src_w_en && !req_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            lat_cnt_reg  <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            sel_reg      <= '0;
            w_en_reg     <= 1'b0;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            wr_count_reg <= '0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            if (mem_we) begin
                wr_count_reg <= wr_count_reg + CNT_WIDTH'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg    <= stb2dcache_addr;
                        wdata_reg   <= stb2dcache_wdata;
                        sel_reg     <= stb2dcache_sel_byte;
                        w_en_reg    <= stb2dcache_w_en;
                        lat_cnt_reg <= lat_cfg;
                        busy_reg    <= 1'b1;
                        if (lat_cfg == '0) begin
                            state_reg <= ACK;
                            ack_reg   <= 1'b1;
                            err_reg   <= req_err;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
                    if (lat_cnt_reg == LAT_W'(1)) begin
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                        err_reg   <= req_err;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign dcache2stb_ack = ack_reg;
    assign busy           = busy_reg;
    assign wr_count       = wr_count_reg;

    dcache_resp_mem #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH),
        .MEM_DEPTH      (MEM_DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .we        (mem_we),
        .waddr     (src_addr[IDX_W+OFF_W-1:OFF_W]),
        .wdata     (src_wdata),
        .sel       (src_sel),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

endmodule

// File: tb/tb_dcache_stb_responder.sv
// Scoreboard bench for dcache_stb_responder: stimulus pushes the expected ack
// (cycle, word, count, err) and a negedge monitor pops and compares on each ack.
module tb_dcache_stb_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stb2dcache_addr;
    logic [31:0] stb2dcache_wdata;
    logic [3:0]  stb2dcache_sel_byte;
    logic        stb2dcache_w_en;
    logic        stb2dcache_req;
    logic        dmem_sel_o;
    logic [1:0]  lat_cfg;
    logic        dcache2stb_ack;
    logic        busy;
    logic [15:0] wr_count;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_rdata;
`ifdef DCACHE_RESP_ERR_EN
    logic        dcache2stb_err;
`endif

    dcache_stb_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .stb2dcache_addr     (stb2dcache_addr),
        .stb2dcache_wdata    (stb2dcache_wdata),
        .stb2dcache_sel_byte (stb2dcache_sel_byte),
        .stb2dcache_w_en     (stb2dcache_w_en),
        .stb2dcache_req      (stb2dcache_req),
        .dmem_sel_o          (dmem_sel_o),
        .lat_cfg             (lat_cfg),
        .dcache2stb_ack      (dcache2stb_ack),
`ifdef DCACHE_RESP_ERR_EN
        .dcache2stb_err      (dcache2stb_err),
`endif
        .busy                (busy),
        .wr_count            (wr_count),
        .dbg_addr            (dbg_addr),
        .dbg_rdata           (dbg_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [31:0] word;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h required=0x%0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dcache2stb_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack got ack=1 required no ack (cyc %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("ack cyc=%0d word[%0d]=0x%08h wr_count=%0d", cyc, dbg_addr, dbg_rdata, wr_count);
                check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("ack_word", 64'(dbg_rdata), 64'(mon_e.word));
                check("ack_wr_count", 64'(wr_count), 64'(mon_e.cnt));
`ifdef DCACHE_RESP_ERR_EN
                check("ack_err", 64'(dcache2stb_err), 64'(mon_e.err));
`endif
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                         input logic wen, input logic [1:0] lat,
                         input logic [31:0] exp_word, input logic [15:0] exp_cnt, input logic exp_err);
        exp_t e;
        bit   got_ack;
        @(posedge clk);
        #1;
        stb2dcache_addr     = addr;
        stb2dcache_wdata    = data;
        stb2dcache_sel_byte = sel;
        stb2dcache_w_en     = wen;
        lat_cfg             = lat;
        stb2dcache_req      = 1'b1;
        dmem_sel_o          = 1'b1;
        dbg_addr            = addr[7:2];
        e.cyc  = cyc + 1 + int'(lat);
        e.word = exp_word;
        e.cnt  = exp_cnt;
        e.err  = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        got_ack = 1'b0;
        for (int i = 0; i < 8 && !got_ack; i++) begin
            @(negedge clk);
            check("busy_inflight", 64'(busy), 64'(1));
            if (dcache2stb_ack === 1'b1) got_ack = 1'b1;
        end
        if (!got_ack) begin
            total++;
            bad++;
            $display("FAIL ack_timeout got no ack required ack within 8 cycles (addr 0x%08h)", addr);
        end
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1;
        stb2dcache_req = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", 64'(dcache2stb_ack), 64'(0));
        check("busy_after_ack", 64'(busy), 64'(0));
    endtask

    task automatic read_word(input logic [5:0] idx, input logic [31:0] want);
        dbg_addr = idx;
        #1;
        $display("read word[%0d]=0x%08h", idx, dbg_rdata);
        check("readback", 64'(dbg_rdata), 64'(want));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        stb2dcache_addr     = '0;
        stb2dcache_wdata    = '0;
        stb2dcache_sel_byte = '0;
        stb2dcache_w_en     = 1'b0;
        stb2dcache_req      = 1'b0;
        dmem_sel_o          = 1'b0;
        lat_cfg             = '0;
        dbg_addr            = 6'd2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ack", 64'(dcache2stb_ack), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_wr_count", 64'(wr_count), 64'(0));
        check("reset_mem", 64'(dbg_rdata), 64'(0));

        // Single full-word store, zero latency.
        issue(32'h08, 32'hDEADBEEF, 4'b1111, 1'b1, 2'd0, 32'hDEADBEEF, 16'd1, 1'b0);
        drop_req();

        // Partial write over a preloaded word.
        issue(32'h0C, 32'h11223344, 4'b1111, 1'b1, 2'd1, 32'h11223344, 16'd2, 1'b0);
        drop_req();
        issue(32'h0C, 32'hAABBCCDD, 4'b0101, 1'b1, 2'd2, 32'h11BB33DD, 16'd3, 1'b0);
        drop_req();

        // Latency sweep.
        issue(32'h10, 32'hA0A0A0A0, 4'b1111, 1'b1, 2'd0, 32'hA0A0A0A0, 16'd4, 1'b0);
        drop_req();
        issue(32'h10, 32'hB1B1B1B1, 4'b1111, 1'b1, 2'd1, 32'hB1B1B1B1, 16'd5, 1'b0);
        drop_req();
        issue(32'h10, 32'hC2C2C2C2, 4'b1111, 1'b1, 2'd2, 32'hC2C2C2C2, 16'd6, 1'b0);
        drop_req();
        issue(32'h10, 32'hD3D3D3D3, 4'b1111, 1'b1, 2'd3, 32'hD3D3D3D3, 16'd7, 1'b0);
        drop_req();

        // Back-to-back with req held high: accept spacing of 3 falls out of the expected cycles.
        issue(32'h00, 32'hCAFE0000, 4'b1111, 1'b1, 2'd1, 32'hCAFE0000, 16'd8, 1'b0);
        issue(32'h04, 32'hCAFE0001, 4'b1111, 1'b1, 2'd1, 32'hCAFE0001, 16'd9, 1'b0);
        issue(32'h08, 32'hCAFE0002, 4'b1111, 1'b1, 2'd1, 32'hCAFE0002, 16'd10, 1'b0);
        issue(32'h0C, 32'hCAFE0003, 4'b1111, 1'b1, 2'd1, 32'hCAFE0003, 16'd11, 1'b0);
        drop_req();
        read_word(6'd0, 32'hCAFE0000);
        read_word(6'd1, 32'hCAFE0001);
        read_word(6'd2, 32'hCAFE0002);
        read_word(6'd3, 32'hCAFE0003);
        check("b2b_wr_count", 64'(wr_count), 64'(11));

        // w_en=0 is acked but neither writes nor counts; sel=0 counts without changing data.
        issue(32'h00, 32'h12345678, 4'b1111, 1'b0, 2'd1, 32'hCAFE0000, 16'd11, 1'b0);
        drop_req();
        issue(32'h04, 32'hFFFFFFFF, 4'b0000, 1'b1, 2'd0, 32'hCAFE0001, 16'd12, 1'b0);
        drop_req();

        // Request without dmem_sel_o must never be accepted.
        @(posedge clk);
        #1;
        stb2dcache_req = 1'b1;
        dmem_sel_o     = 1'b0;
        repeat (6) @(negedge clk);
        check("no_sel_busy", 64'(busy), 64'(0));
        check("no_sel_wr_count", 64'(wr_count), 64'(12));
        stb2dcache_req = 1'b0;
        dmem_sel_o     = 1'b1;

`ifdef DCACHE_RESP_ERR_EN
        // Out-of-range and word-crossing stores: ack with err, no write, no count.
        issue(32'h100, 32'h77777777, 4'b1111, 1'b1, 2'd1, 32'hCAFE0000, 16'd12, 1'b1);
        drop_req();
        issue(32'h16, 32'h77777777, 4'b0100, 1'b1, 2'd0, 32'h00000000, 16'd12, 1'b1);
        drop_req();
        issue(32'h15, 32'h5A5A5A5A, 4'b0011, 1'b1, 2'd2, 32'h00005A5A, 16'd13, 1'b0);
        drop_req();
`else
        // High and offset address bits are ignored: index = addr[7:2] = 5.
        issue(32'hFFFF_FF17, 32'h5A5A5A5A, 4'b0011, 1'b1, 2'd2, 32'h00005A5A, 16'd13, 1'b0);
        drop_req();
`endif

        // Reset during WAIT drops the store: no ack, no write, everything cleared.
        @(posedge clk);
        #1;
        stb2dcache_addr     = 32'h18;
        stb2dcache_wdata    = 32'h99999999;
        stb2dcache_sel_byte = 4'b1111;
        stb2dcache_w_en     = 1'b1;
        lat_cfg             = 2'd3;
        stb2dcache_req      = 1'b1;
        dbg_addr            = 6'd6;
        @(posedge clk);
        @(negedge clk);
        check("busy_before_rst", 64'(busy), 64'(1));
        rst            = 1'b1;
        stb2dcache_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_wr_count", 64'(wr_count), 64'(0));
        read_word(6'd6, 32'h00000000);
        read_word(6'd2, 32'h00000000);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_stb_responder.md
Name: dcache_stb_responder

Overview:
- Data-cache-side responder for the store buffer write interface; the other end of the stb2dcache_* / dcache2stb_ack handshake.
- Accepts one store at a time from store_buffer_top and commits it as a byte-masked write into an internal word memory.
- Returns a single-cycle dcache2stb_ack after a per-request programmable latency.
- Serves as the dcache model in store-buffer system benches and as the write front-end of the future dcache.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data word width.
- BYTE_SEL_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- MEM_DEPTH, 64, number of words in the internal memory (power of 2).
- CNT_WIDTH, 16, width of the committed-write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stb2dcache_addr  in  ADDR_WIDTH  byte address of the store.
- stb2dcache_wdata  in  DATA_WIDTH  store data.
- stb2dcache_sel_byte  in  BYTE_SEL_WIDTH  byte enables; bit i selects wdata[8i+7:8i].
- stb2dcache_w_en  in  1  write enable.
- stb2dcache_req  in  1  request valid; held high by the store buffer until ack.
- dmem_sel_o  in  1  data-memory select from the store buffer; a request is valid only while this is 1.
- lat_cfg  in  2  extra wait cycles (0-3); sampled at accept.
- dcache2stb_ack  out  1  one-cycle acknowledge to the store buffer.
- busy  out  1  high while a request is in flight (WAIT or ACK).
- wr_count  out  CNT_WIDTH  number of committed writes.
- dbg_addr  in  $clog2(MEM_DEPTH)  word index for the bench readback port.
- dbg_rdata  out  DATA_WIDTH  combinational read of mem[dbg_addr].

Behaviour:
- Reset (async, rst=1): FSM state IDLE; dcache2stb_ack=0; busy=0; wr_count=0; all memory words 0; capture registers 0. Reset mid-operation drops the pending store: no write and no ack.
- FSM states:
  - IDLE: accept when stb2dcache_req and dmem_sel_o are both 1. On the accept edge, capture addr, wdata, sel_byte, w_en and lat_cfg into lat_cnt. Go to WAIT if lat_cfg>0, otherwise go to ACK.
  - WAIT: decrement lat_cnt each cycle. Go to ACK on the edge where lat_cnt==1.
  - ACK: dcache2stb_ack=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: ack is high in cycle 1+lat_cfg after the accept edge (minimum 1 cycle, maximum 4).
- busy = (state != IDLE).
- Memory commit occurs on the edge that enters ACK, so the stored word is visible on dbg_rdata in the same cycle ack is high.
- Word index = captured addr[$clog2(MEM_DEPTH)+1:2]. addr[1:0] and higher address bits are ignored.
- Byte lane i is written only if sel_byte[i]=1. sel_byte=0 performs no data change but still counts as a committed write.
- Captured w_en=0: the request is still acked, memory is untouched and wr_count does not increment.
- wr_count increments by 1 per committed write (w_en=1) and wraps modulo 2^CNT_WIDTH.
- Request inputs are ignored in WAIT and ACK. Changes to them after accept do not affect the in-flight store.
- A request still high in the ACK cycle is not accepted. It is accepted in the following IDLE cycle if still valid, so back-to-back stores have accept-to-accept spacing of at least 2+lat_cfg cycles.
- req=1 with dmem_sel_o=0: not accepted; no ack is generated.

Optional Feature:
- Macro: DCACHE_RESP_ERR_EN.
- When defined:
  - Adds output dcache2stb_err (1 bit), asserted only in the ACK cycle of an erroneous request.
  - An erroneous request has captured addr >= MEM_DEPTH*4, or addr[1:0] != 0 with a sel_byte lane that falls beyond the word.
  - For erroneous requests the write is suppressed and wr_count is not incremented.
  - Reset value 0.
- When undefined: the port is absent and all addresses wrap into the memory by index truncation.

Decomposition:
- dcache_resp_pkg holds:
  - enum resp_state_e {IDLE, WAIT, ACK}.
  - Localparams WORD_IDX_W=$clog2(MEM_DEPTH) and LAT_W=2.
  - Function byte_merge(old, new, sel), which returns the per-lane merge.
- One sub-module, dcache_resp_mem, is natural: MEM_DEPTH x DATA_WIDTH array with async clear, a byte-masked write port and a combinational debug read port.

Test Plan:
- Reset then a single store (addr=0x08, wdata=0xDEADBEEF, sel=4'b1111, lat_cfg=0) -> ack high exactly 1 cycle after accept; dbg_addr=2 reads 0xDEADBEEF; wr_count=1.
- Partial write: preload word 3 with 0x11223344, then store 0xAABBCCDD with sel=4'b0101 -> word 3 reads 0x11BB33DD.
- Latency sweep: lat_cfg=0,1,2,3 -> ack at 1,2,3,4 cycles after accept; busy high throughout; exactly one ack per request.
- Back-to-back: hold req high across 4 stores to words 0-3, lat_cfg=1 -> 4 acks spaced 3 cycles apart; all 4 words correct; wr_count=4.
- Reset mid-flight: accept a store with lat_cfg=3, assert rst during WAIT -> no ack; target word reads 0; wr_count=0.
- DCACHE_RESP_ERR_EN: store to addr=0x100 with MEM_DEPTH=64 -> ack and err in the same cycle; no memory change; wr_count unchanged.
